// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: arbitrates host reads and DMA against the RX FIFO and raises RX interrupts.
// Optional character timeout is compiled in with `define UART_RX_TIMEOUT_EN.
module uart_rx_ctrl #(
   parameter int FIFO_COUNTER_W = 5,
   parameter int FIFO_DEPTH     = 16,
   parameter int TOUT_CYCLES    = 640
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [FIFO_COUNTER_W-1:0] rf_count,
   input  logic [10:0]               rf_data,
   input  logic                      rx_push,
   output logic                      rf_pop,
   input  logic [1:0]                trig_lvl,
   input  logic                      host_rd,
   output logic [7:0]                host_rdata,
   output logic                      host_rvalid,
   input  logic                      dma_req,
   output logic                      dma_ack,
   output logic [7:0]                dma_data,
   input  logic                      lsr_clr,
   output logic                      int_rda,
   output logic                      int_tout,
   output logic                      lsr_err
);

   typedef enum logic [1:0] {IDLE, POP, CAP, EMPTY} state_t;

   state_t     state_reg;
   logic       host_pend_reg;
   logic       grant_host_reg;
   logic       rf_pop_reg;
   logic       host_rvalid_reg;
   logic       dma_ack_reg;
   logic       lsr_err_reg;
   logic       int_rda_reg;
   logic [7:0] host_rdata_reg;
   logic [7:0] dma_data_reg;

   logic host_want;
   logic fifo_nonempty;
   int   rda_thr;

   if (TOUT_CYCLES < 1 || FIFO_DEPTH < 1) begin : g_param_check
      $error("uart_rx_ctrl: TOUT_CYCLES and FIFO_DEPTH must be positive");
   end

   assign host_want     = host_pend_reg | host_rd;
   assign fifo_nonempty = (rf_count != '0);

   // Trigger level never exceeds what the FIFO can actually hold.
   always_comb begin
      rda_thr = 1;
      case (trig_lvl)
         2'b00:   rda_thr = 1;
         2'b01:   rda_thr = 4;
         2'b10:   rda_thr = 8;
         default: rda_thr = 14;
      endcase
      if (rda_thr > FIFO_DEPTH)
         rda_thr = FIFO_DEPTH;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         host_pend_reg   <= 1'b0;
         grant_host_reg  <= 1'b0;
         rf_pop_reg      <= 1'b0;
         host_rvalid_reg <= 1'b0;
         dma_ack_reg     <= 1'b0;
         lsr_err_reg     <= 1'b0;
         int_rda_reg     <= 1'b0;
         host_rdata_reg  <= 8'h00;
         dma_data_reg    <= 8'h00;
      end else begin
         rf_pop_reg      <= 1'b0;
         host_rvalid_reg <= 1'b0;
         dma_ack_reg     <= 1'b0;
         int_rda_reg     <= (int'(rf_count) >= rda_thr);
         if (host_rd)
            host_pend_reg <= 1'b1;
         if (lsr_clr)
            lsr_err_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (host_want && fifo_nonempty) begin
                  state_reg      <= POP;
                  rf_pop_reg     <= 1'b1;
                  grant_host_reg <= 1'b1;
               end else if (host_want) begin
                  state_reg       <= EMPTY;
                  host_rvalid_reg <= 1'b1;
                  host_rdata_reg  <= 8'h00;
                  host_pend_reg   <= 1'b0;
               end else if (dma_req && fifo_nonempty) begin
                  state_reg      <= POP;
                  rf_pop_reg     <= 1'b1;
                  grant_host_reg <= 1'b0;
               end
            end
            POP: begin
               state_reg <= CAP;
               if (grant_host_reg) begin
                  host_rvalid_reg <= 1'b1;
                  host_pend_reg   <= 1'b0;
               end else begin
                  dma_ack_reg <= 1'b1;
               end
            end
            CAP: begin
               // FIFO head is only valid now, so the hold registers latch it as CAP ends.
               state_reg <= IDLE;
               if (grant_host_reg)
                  host_rdata_reg <= rf_data[10:3];
               else
                  dma_data_reg <= rf_data[10:3];
               if (rf_data[2:0] != 3'b000)
                  lsr_err_reg <= 1'b1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign rf_pop      = rf_pop_reg;
   assign host_rvalid = host_rvalid_reg;
   assign dma_ack     = dma_ack_reg;
   assign lsr_err     = lsr_err_reg;
   assign int_rda     = int_rda_reg;
   assign host_rdata  = (state_reg == CAP &&  grant_host_reg) ? rf_data[10:3] : host_rdata_reg;
   assign dma_data    = (state_reg == CAP && !grant_host_reg) ? rf_data[10:3] : dma_data_reg;

`ifdef UART_RX_TIMEOUT_EN
   localparam int TOUT_W = $clog2(TOUT_CYCLES + 1);
   localparam logic [TOUT_W-1:0] TOUT_MAX = TOUT_CYCLES[TOUT_W-1:0];

   logic [TOUT_W-1:0] tout_cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tout_cnt_reg <= '0;
      else if (rx_push || rf_pop_reg)
         tout_cnt_reg <= '0;
      else if (fifo_nonempty && tout_cnt_reg != TOUT_MAX)
         tout_cnt_reg <= tout_cnt_reg + 1'b1;
   end

   assign int_tout = (tout_cnt_reg == TOUT_MAX);
`else
   assign int_tout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: models the RX FIFO, runs a directed vector table, corner sequences and random traffic.
module tb_uart_rx_ctrl;

`ifdef UART_RX_TIMEOUT_EN
   localparam bit TOUT_ON = 1'b1;
`else
   localparam bit TOUT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  rf_count = '0;
   logic [10:0] rf_data = '0;
   logic        rx_push = 1'b0;
   logic        rf_pop;
   logic [1:0]  trig_lvl = 2'b00;
   logic        host_rd = 1'b0;
   logic [7:0]  host_rdata;
   logic        host_rvalid;
   logic        dma_req = 1'b0;
   logic        dma_ack;
   logic [7:0]  dma_data;
   logic        lsr_clr = 1'b0;
   logic        int_rda;
   logic        int_tout;
   logic        lsr_err;

   logic [10:0] push_data = '0;
   logic [10:0] q[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   uart_rx_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .rf_count    (rf_count),
      .rf_data     (rf_data),
      .rx_push     (rx_push),
      .rf_pop      (rf_pop),
      .trig_lvl    (trig_lvl),
      .host_rd     (host_rd),
      .host_rdata  (host_rdata),
      .host_rvalid (host_rvalid),
      .dma_req     (dma_req),
      .dma_ack     (dma_ack),
      .dma_data    (dma_data),
      .lsr_clr     (lsr_clr),
      .int_rda     (int_rda),
      .int_tout    (int_tout),
      .lsr_err     (lsr_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int thr(input logic [1:0] t);
      case (t)
         2'b00:   return 1;
         2'b01:   return 4;
         2'b10:   return 8;
         default: return 14;
      endcase
   endfunction

   // One clock: the FIFO model reacts to the pop/push the DUT saw at the edge; ends on a falling edge.
   task automatic step();
      bit          pop_s  = rf_pop;
      bit          push_s = rx_push;
      logic [10:0] pd     = push_data;
      @(posedge clk);
      #1;
      if (pop_s && q.size() > 0) rf_data = q.pop_front();
      if (push_s) q.push_back(pd);
      rf_count = 5'(q.size());
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      host_rd = 0; dma_req = 0; rx_push = 0; lsr_clr = 0; trig_lvl = 2'b00;
      q.delete();
      rf_count = '0;
      rf_data = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {rf_pop, host_rvalid, dma_ack, int_rda, int_tout, lsr_err, host_rdata, dma_data}, 0);
      rst = 1'b0;
   endtask

   task automatic preload(input int n, input logic [2:0] fl);
      for (int i = 0; i < n; i++) q.push_back({8'(8'hA0 + i), fl});
      rf_count = 5'(q.size());
   endtask

   typedef struct {
      int         nchars;
      bit         host;
      bit         dma;
      int         exp_pop;
      int         exp_rv;
      int         exp_ack;
      logic [7:0] exp_rdata;
      logic [7:0] exp_ddata;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int first_pop, first_rv, first_ack, npop;
      logic [7:0] rvd, ackd;
      int cnt_prev, host_age;
      logic [1:0] trig_prev;
      bit pop_prev, cap_prev, new_cap, clr_prev, lsr_exp, host_out;
      logic [2:0] cap_flags, new_flags;

      vecs[0] = '{nchars: 3, host: 1, dma: 0, exp_pop: 1,  exp_rv: 2,  exp_ack: -1, exp_rdata: 8'hA0, exp_ddata: 8'h00};
      vecs[1] = '{nchars: 0, host: 1, dma: 0, exp_pop: -1, exp_rv: 1,  exp_ack: -1, exp_rdata: 8'h00, exp_ddata: 8'h00};
      vecs[2] = '{nchars: 2, host: 1, dma: 1, exp_pop: 1,  exp_rv: 2,  exp_ack: 5,  exp_rdata: 8'hA0, exp_ddata: 8'hA1};
      vecs[3] = '{nchars: 0, host: 0, dma: 1, exp_pop: -1, exp_rv: -1, exp_ack: -1, exp_rdata: 8'h00, exp_ddata: 8'h00};
      vecs[4] = '{nchars: 1, host: 0, dma: 1, exp_pop: 1,  exp_rv: -1, exp_ack: 2,  exp_rdata: 8'h00, exp_ddata: 8'hA0};

      @(negedge clk);

      // Directed vectors: cycle 0 is the cycle the request is presented.
      for (int v = 0; v < 5; v++) begin
         do_reset();
         preload(vecs[v].nchars, 3'b000);
         host_rd = vecs[v].host;
         dma_req = vecs[v].dma;
         first_pop = -1; first_rv = -1; first_ack = -1; npop = 0;
         rvd = 8'h00; ackd = 8'h00;
         for (int c = 1; c <= 10; c++) begin
            step();
            host_rd = 1'b0;
            if (rf_pop) begin
               npop++;
               if (first_pop < 0) first_pop = c;
               chk("pop_nonempty", {27'd0, rf_count}, (rf_count == 0) ? 32'd1 : {27'd0, rf_count});
            end
            if (host_rvalid && first_rv < 0) begin first_rv = c; rvd = host_rdata; end
            if (dma_ack && first_ack < 0) begin first_ack = c; ackd = dma_data; dma_req = 1'b0; end
         end
         dma_req = 1'b0;
         $display("vec %0d: chars=%0d host=%0d dma=%0d pop@%0d rvalid@%0d ack@%0d rdata=%02h ddata=%02h",
                  v, vecs[v].nchars, vecs[v].host, vecs[v].dma, first_pop, first_rv, first_ack, rvd, ackd);
         chk("vec_pop_cycle", first_pop, vecs[v].exp_pop);
         chk("vec_rvalid_cycle", first_rv, vecs[v].exp_rv);
         chk("vec_ack_cycle", first_ack, vecs[v].exp_ack);
         chk("vec_pop_count", npop, (vecs[v].exp_pop >= 0 ? 1 : 0) + (vecs[v].exp_ack > vecs[v].exp_rv && vecs[v].exp_rv > 0 && vecs[v].exp_pop >= 0 ? 1 : 0));
         if (vecs[v].exp_rv >= 0)  chk("vec_host_rdata", rvd, vecs[v].exp_rdata);
         if (vecs[v].exp_ack >= 0) chk("vec_dma_data", ackd, vecs[v].exp_ddata);
      end

      // RDA threshold crossing up and down.
      do_reset();
      trig_lvl = 2'b01;
      rx_push = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_data = {8'(8'h10 + i), 3'b000};
         step();
      end
      rx_push = 1'b0;
      chk("rda_at_count4", int_rda, 0);
      step();
      chk("rda_rise", int_rda, 1);
      host_rd = 1'b1;
      step();
      host_rd = 1'b0;
      chk("rda_pop_visible", rf_pop, 1);
      step();
      chk("rda_count3_cycle", int_rda, 1);
      step();
      chk("rda_fall", int_rda, 0);
      $display("rda seq: trig=01 rise/fall observed, int_rda=%0b", int_rda);

      // Error flag capture, clear, and set-beats-clear.
      do_reset();
      q.push_back({8'h5A, 3'b100});
      q.push_back({8'h3C, 3'b001});
      rf_count = 5'(q.size());
      host_rd = 1'b1;
      step();
      host_rd = 1'b0;
      step();
      chk("lsr_host_rdata", host_rdata, 8'h5A);
      chk("lsr_not_yet", lsr_err, 0);
      step();
      chk("lsr_set", lsr_err, 1);
      chk("rdata_hold", host_rdata, 8'h5A);
      lsr_clr = 1'b1;
      step();
      lsr_clr = 1'b0;
      chk("lsr_clear", lsr_err, 0);
      host_rd = 1'b1;
      step();
      host_rd = 1'b0;
      step();
      lsr_clr = 1'b1;
      step();
      lsr_clr = 1'b0;
      chk("lsr_set_wins", lsr_err, 1);
      chk("rdata_hold2", host_rdata, 8'h3C);
      $display("lsr seq: lsr_err=%0b host_rdata=%02h", lsr_err, host_rdata);

      // Reset arriving while a pop is in flight, then the first request after release.
      do_reset();
      preload(2, 3'b000);
      host_rd = 1'b1;
      step();
      host_rd = 1'b0;
      chk("pop_before_rst", rf_pop, 1);
      rst = 1'b1;
      #1;
      chk("rst_kills_pop", rf_pop, 0);
      chk("rst_outputs", {host_rvalid, dma_ack, int_rda, int_tout, lsr_err, host_rdata, dma_data}, 0);
      @(negedge clk);
      rst = 1'b0;
      host_rd = 1'b1;
      step();
      host_rd = 1'b0;
      chk("first_req_after_rst", rf_pop, 1);
      step();
      $display("rst seq: pop aborted, first request after reset popped, rdata=%02h", host_rdata);

      // Character timeout: one character left sitting in the FIFO.
      do_reset();
      push_data = {8'h77, 3'b000};
      rx_push = 1'b1;
      step();
      rx_push = 1'b0;
      repeat (639) step();
      chk("tout_before", int_tout, 0);
      step();
      chk("tout_reached", int_tout, TOUT_ON);
      host_rd = 1'b1;
      step();
      host_rd = 1'b0;
      chk("tout_during_pop", int_tout, TOUT_ON);
      step();
      chk("tout_cleared", int_tout, 0);
      $display("tout seq: enabled=%0b", TOUT_ON);

      // Random traffic against a FIFO-order / pulse-accounting reference.
      do_reset();
      pop_prev = 0; cap_prev = 0; cap_flags = 0; lsr_exp = 0; host_out = 0; host_age = 0;
      for (int t = 0; t < 1000; t++) begin
         if (t < 950) begin
            if (t % 100 == 0) trig_lvl = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) dma_req = ~dma_req;
            rx_push = (q.size() < 15) && ($urandom_range(0, 2) == 0);
            push_data = 11'($urandom);
            lsr_clr = ($urandom_range(0, 9) == 0);
            host_rd = !host_out && ($urandom_range(0, 5) == 0);
            if (host_rd) begin host_out = 1; host_age = 0; end
         end else begin
            dma_req = 0; rx_push = 0; lsr_clr = 0; host_rd = 0;
         end
         if (rf_pop && rf_count == 0) chk("rand_pop_empty", rf_pop, 0);
         cnt_prev = rf_count;
         trig_prev = trig_lvl;
         clr_prev = lsr_clr;
         step();
         host_rd = 1'b0;

         chk("rand_int_rda", int_rda, (cnt_prev >= thr(trig_prev)) ? 1 : 0);
         new_cap = 0;
         new_flags = 3'b000;
         if (pop_prev) begin
            chk("rand_one_valid", host_rvalid + dma_ack, 1);
            if (host_rvalid) chk("rand_host_data", host_rdata, rf_data[10:3]);
            if (dma_ack)     chk("rand_dma_data", dma_data, rf_data[10:3]);
            new_cap = 1;
            new_flags = rf_data[2:0];
            $display("t=%0d char %02h flags %0b -> %s", t, rf_data[10:3], rf_data[2:0], host_rvalid ? "host" : "dma");
         end else begin
            chk("rand_no_dma_ack", dma_ack, 0);
            if (host_rvalid) begin
               chk("rand_empty_data", host_rdata, 8'h00);
               $display("t=%0d empty read -> host 00", t);
            end
         end
         if (host_rvalid) begin
            chk("rand_host_expected", host_out, 1);
            host_out = 0;
         end
         lsr_exp = (cap_prev && cap_flags != 3'b000) || (lsr_exp && !clr_prev);
         chk("rand_lsr_err", lsr_err, lsr_exp);
         cap_prev = new_cap;
         cap_flags = new_flags;
         pop_prev = rf_pop;
         if (host_out) begin
            host_age++;
            if (host_age == 12) chk("rand_host_latency", host_out, 0);
         end
      end
      chk("rand_host_drained", host_out, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter FIFO_COUNTER_W, default 5, is the width of the receive FIFO fill count.
REQ-002 Parameter FIFO_DEPTH, default 16, is the receive FIFO capacity in characters.
REQ-003 Parameter TOUT_CYCLES, default 640, is the character-timeout threshold in clk cycles.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  the single clock; all flops sample on the rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 rf_count  in  FIFO_COUNTER_W  receive FIFO fill count.
REQ-008 rf_data  in  11  FIFO head: {data[7:0], flags[2:0]}, valid one cycle after pop.
REQ-009 rx_push  in  1  receive FIFO write strobe (character arrived).
REQ-010 rf_pop  out  1  receive FIFO pop strobe, single-cycle pulse.
REQ-011 trig_lvl  in  2  RDA trigger level: 00=1, 01=4, 10=8, 11=14 characters.
REQ-012 host_rd  in  1  host read request pulse.
REQ-013 host_rdata  out  8  host read data.
REQ-014 host_rvalid  out  1  host read data valid, single-cycle pulse.
REQ-015 dma_req  in  1  DMA request level.
REQ-016 dma_ack  out  1  DMA data valid/acknowledge, single-cycle pulse.
REQ-017 dma_data  out  8  DMA read data.
REQ-018 lsr_clr  in  1  clears lsr_err.
REQ-019 int_rda  out  1  receive-data-available interrupt.
REQ-020 int_tout  out  1  character-timeout interrupt.
REQ-021 lsr_err  out  1  sticky "errored character delivered" flag.

Function
REQ-022 FSM states IDLE, POP, CAP, EMPTY; IDLE is the reset state.
REQ-023 Requests are arbitrated only in IDLE; a pending host read takes priority over dma_req.
REQ-024 A host_rd pulse sets host_pend, which clears on the cycle host_rvalid asserts; further pulses while host_pend=1 are ignored.
REQ-025 IDLE with a winner and rf_count>0 -> POP: rf_pop=1 for exactly one cycle, grant registered -> CAP.
REQ-026 CAP: rf_data captured; the granted requester's valid pulse (host_rvalid or dma_ack) and data[7:0] are asserted this cycle -> IDLE.
REQ-027 IDLE with host_pend=1 and rf_count==0 -> EMPTY: host_rvalid=1, host_rdata=0x00, no pop -> IDLE.
REQ-028 dma_req with rf_count==0 is not served and produces no pulse.
REQ-029 Pop-to-data latency: 1 cycle; request-to-valid latency: 2 cycles from IDLE; peak throughput: one character per 3 cycles.
REQ-030 rf_pop shall never assert while rf_count==0.
REQ-031 host_rdata and dma_data hold their last value between valid pulses.
REQ-032 lsr_err sets in CAP when captured flags[2:0]!=0; lsr_clr clears it; a simultaneous set wins over clear.
REQ-033 int_rda is registered: 1 the cycle after rf_count >= trig_lvl threshold; 0 the cycle after it falls below.

Reset
REQ-034 Asserting rst in any state, including POP, forces IDLE, rf_pop=0, host_pend=0, and every output to 0 asynchronously.
REQ-035 The first request is accepted on the first clk edge after rst deasserts.

Configuration
REQ-036 Macro UART_RX_TIMEOUT_EN compiles in the character timeout.
REQ-037 With the macro: a counter clears on rx_push or rf_pop, increments while rf_count>0 and saturates at TOUT_CYCLES; int_tout=1 while the counter == TOUT_CYCLES.
REQ-038 Without the macro: int_tout is tied to 0 and no counter exists.

Verification
REQ-039 FIFO count=3, host_rd pulse -> rf_pop 1 cycle later; host_rvalid 2 cycles later with rf_data[10:3].
REQ-040 rf_count=0, host_rd -> host_rvalid next cycle, host_rdata=0x00, rf_pop never asserted.
REQ-041 host_rd and dma_req in the same cycle, count=2 -> host is served first, then dma_ack 3 cycles later.
REQ-042 trig_lvl=01, push 4 characters -> int_rda rises 1 cycle after count reaches 4 and falls after the pop to 3.
REQ-043 Macro defined, 1 character left idle for 640 cycles -> int_tout=1; a pop clears it next cycle.
REQ-044 Captured flags=3'b100 -> lsr_err=1; lsr_clr -> 0; rst asserted during POP -> rf_pop drops immediately.
